// File: rtl/pixel_scanout.sv
// pixel_scanout: plot-port framebuffer (4 bits per channel) with scaled
// VGA scan-out through a two-stage pix_en pipeline.
module pixel_scanout #(
    parameter int H_RES  = 160,
    parameter int V_RES  = 120,
    parameter int SCALE  = 4,
    parameter int H_VIS  = 640,
    parameter int H_FP   = 16,
    parameter int H_SYNC = 96,
    parameter int H_BP   = 48,
    parameter int V_VIS  = 480,
    parameter int V_FP   = 10,
    parameter int V_SYNC = 2,
    parameter int V_BP   = 33
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pix_en,
    input  logic [7:0]  wr_x,
    input  logic [7:0]  wr_y,
    input  logic [23:0] wr_colour,
    input  logic        wr_plot,
    output logic [7:0]  vga_r,
    output logic [7:0]  vga_g,
    output logic [7:0]  vga_b,
    output logic        vga_hs,
    output logic        vga_vs,
    output logic        vga_blank_n,
    output logic        vblank_start
);
    localparam int DEPTH = H_RES * V_RES;
    localparam int AW    = $clog2(DEPTH);
    localparam int SH    = $clog2(SCALE);

    localparam logic [9:0] H_LAST = 10'(H_VIS + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] V_LAST = 10'(V_VIS + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0] H_VISC = 10'(H_VIS);
    localparam logic [9:0] V_VISC = 10'(V_VIS);
    localparam logic [9:0] V_VBL  = 10'(V_VIS - 1);
    localparam logic [9:0] HS_BEG = 10'(H_VIS + H_FP);
    localparam logic [9:0] HS_END = 10'(H_VIS + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_BEG = 10'(V_VIS + V_FP);
    localparam logic [9:0] VS_END = 10'(V_VIS + V_FP + V_SYNC - 1);
    localparam logic [7:0] X_LIM  = 8'(H_RES);
    localparam logic [7:0] Y_LIM  = 8'(V_RES);

    logic [11:0] mem [DEPTH];

    logic [9:0]  hCnt;
    logic [9:0]  vCnt;
    logic [14:0] wrAddr;
    logic [14:0] rdAddr;
    logic        wrOk;
    logic        visible;
    logic        hsNow;
    logic        vsNow;
    logic [11:0] rdData;
    logic        hsD;
    logic        vsD;
    logic        blankD;

    assign wrOk    = wr_plot && (wr_x < X_LIM) && (wr_y < Y_LIM);
    assign wrAddr  = 15'(wr_x) + 15'(wr_y) * 15'(H_RES);
    assign visible = (hCnt < H_VISC) && (vCnt < V_VISC);
    assign hsNow   = !((hCnt >= HS_BEG) && (hCnt <= HS_END));
    assign vsNow   = !((vCnt >= VS_BEG) && (vCnt <= VS_END));
    // Blanked positions read address 0 so the index never leaves the array.
    assign rdAddr  = visible ? 15'(hCnt >> SH) + 15'(vCnt >> SH) * 15'(H_RES)
                             : 15'd0;

    always_ff @(posedge clk) begin
        if (wrOk) begin
            mem[wrAddr[AW-1:0]] <= {wr_colour[23:20], wr_colour[15:12],
                                    wr_colour[7:4]};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hCnt         <= '0;
            vCnt         <= '0;
            rdData       <= '0;
            hsD          <= 1'b1;
            vsD          <= 1'b1;
            blankD       <= 1'b0;
            vga_r        <= '0;
            vga_g        <= '0;
            vga_b        <= '0;
            vga_hs       <= 1'b1;
            vga_vs       <= 1'b1;
            vga_blank_n  <= 1'b0;
            vblank_start <= 1'b0;
        end else begin
            vblank_start <= pix_en && (hCnt == H_LAST) && (vCnt == V_VBL);
            if (pix_en) begin
                if (hCnt == H_LAST) begin
                    hCnt <= '0;
                    vCnt <= (vCnt == V_LAST) ? 10'd0 : vCnt + 10'd1;
                end else begin
                    hCnt <= hCnt + 10'd1;
                end
                rdData      <= mem[rdAddr[AW-1:0]];
                hsD         <= hsNow;
                vsD         <= vsNow;
                blankD      <= visible;
                // nibble*17 is the nibble repeated in both halves of the byte
                vga_r       <= blankD ? {rdData[11:8], rdData[11:8]} : 8'd0;
                vga_g       <= blankD ? {rdData[7:4], rdData[7:4]} : 8'd0;
                vga_b       <= blankD ? {rdData[3:0], rdData[3:0]} : 8'd0;
                vga_hs      <= hsD;
                vga_vs      <= vsD;
                vga_blank_n <= blankD;
            end
        end
    end
endmodule

// File: tb/tb_pixel_scanout.sv
// Bench for pixel_scanout on a shrunken timing so whole frames fit the run;
// outputs are compared every clk against a position/framebuffer model.
module tb_pixel_scanout;
    localparam int H_RES  = 16;
    localparam int V_RES  = 12;
    localparam int SCALE  = 2;
    localparam int H_VIS  = 32;
    localparam int H_FP   = 2;
    localparam int H_SYNC = 4;
    localparam int H_BP   = 2;
    localparam int V_VIS  = 24;
    localparam int V_FP   = 2;
    localparam int V_SYNC = 2;
    localparam int V_BP   = 2;
    localparam int H_TOT  = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOT  = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int FRAME  = H_TOT * V_TOT;
    localparam int DEPTH  = H_RES * V_RES;
    localparam int VBL_POS = (V_VIS - 1) * H_TOT + H_TOT - 1;
    localparam logic [27:0] RESET_V = 28'h000000C;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        pix_en = 1'b0;
    logic [7:0]  wr_x = '0;
    logic [7:0]  wr_y = '0;
    logic [23:0] wr_colour = '0;
    logic        wr_plot = 1'b0;
    logic [7:0]  vga_r;
    logic [7:0]  vga_g;
    logic [7:0]  vga_b;
    logic        vga_hs;
    logic        vga_vs;
    logic        vga_blank_n;
    logic        vblank_start;

    int checks = 0;
    int failures = 0;

    // model state: counter position, one in-flight read, expected outputs
    int          p = 0;
    bit          s0Valid = 0;
    int          s0Pos = 0;
    logic [11:0] s0Col = '0;
    bit          s0Known = 1;
    logic [27:0] expV = RESET_V;
    logic [27:0] expMask = '1;
    logic [11:0] fb [DEPTH];
    bit          known [DEPTH];

    pixel_scanout #(
        .H_RES(H_RES), .V_RES(V_RES), .SCALE(SCALE),
        .H_VIS(H_VIS), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_VIS(V_VIS), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
    ) dut (
        .clk(clk), .reset(reset), .pix_en(pix_en),
        .wr_x(wr_x), .wr_y(wr_y), .wr_colour(wr_colour), .wr_plot(wr_plot),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
        .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_blank_n(vga_blank_n),
        .vblank_start(vblank_start)
    );

    always #5 clk = ~clk;

    function automatic logic [27:0] act();
        return {vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_blank_n, vblank_start};
    endfunction

    function automatic logic [27:0] outOf(int q, logic [11:0] c);
        int h, v;
        logic bl, hs, vs;
        logic [7:0] r, g, b;
        h  = q % H_TOT;
        v  = q / H_TOT;
        bl = (h < H_VIS) && (v < V_VIS);
        hs = !(h >= H_VIS + H_FP && h < H_VIS + H_FP + H_SYNC);
        vs = !(v >= V_VIS + V_FP && v < V_VIS + V_FP + V_SYNC);
        r  = bl ? 8'(int'(c[11:8]) * 17) : 8'd0;
        g  = bl ? 8'(int'(c[7:4]) * 17) : 8'd0;
        b  = bl ? 8'(int'(c[3:0]) * 17) : 8'd0;
        return {r, g, b, hs, vs, bl, 1'b0};
    endfunction

    task automatic step();
        logic [27:0] o;
        int a, h, v;
        if (reset) begin
            p = 0;
            s0Valid = 0;
            expV = RESET_V;
            expMask = '1;
        end else if (pix_en) begin
            o = s0Valid ? outOf(s0Pos, s0Col) : RESET_V;
            o[0] = (p == VBL_POS);
            expV = o;
            expMask = (s0Valid && !s0Known) ? 28'h000000F : '1;
            h = p % H_TOT;
            v = p / H_TOT;
            s0Valid = 1;
            s0Pos = p;
            if (h < H_VIS && v < V_VIS) begin
                a = h / SCALE + (v / SCALE) * H_RES;
                s0Col = fb[a];
                s0Known = known[a];
            end else begin
                s0Col = '0;
                s0Known = 1;
            end
            p = (p + 1) % FRAME;
        end else begin
            expV[0] = 1'b0;
        end
        if (wr_plot && int'(wr_x) < H_RES && int'(wr_y) < V_RES) begin
            a = int'(wr_x) + int'(wr_y) * H_RES;
            fb[a] = {wr_colour[23:20], wr_colour[15:12], wr_colour[7:4]};
            known[a] = 1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic randPlot(int margin);
        wr_plot = ($urandom_range(0, 2) == 0);
        wr_x = 8'($urandom_range(0, H_RES - 1 + margin));
        wr_y = 8'($urandom_range(0, V_RES - 1 + margin));
        wr_colour = 24'($urandom);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        pix_en = 1'b0;
        wr_plot = 1'b0;
        for (int i = 0; i < 3; i++) begin
            pix_en = i[0];
            step();
            checks++;
            if (act() !== RESET_V) begin
                failures++;
                $display("FAIL reset_values got=%h exp=%h", act(), RESET_V);
            end
        end
        reset = 1'b0;
        pix_en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            checks++;
            if ((act() & expMask) !== (expV & expMask)) begin
                failures++;
                $display("FAIL reset_start p=%0d got=%h exp=%h", p, act(), expV);
            end
        end
    endtask

    task automatic test_fill();
        for (int a = 0; a < DEPTH; a++) begin
            wr_plot = 1'b1;
            wr_x = 8'(a % H_RES);
            wr_y = 8'(a / H_RES);
            wr_colour = 24'($urandom);
            pix_en = a[0];
            step();
            checks++;
            if ((act() & expMask) !== (expV & expMask)) begin
                failures++;
                $display("FAIL fill p=%0d got=%h exp=%h", p, act(), expV);
            end
        end
        wr_plot = 1'b0;
    endtask

    task automatic test_frame();
        int ticks = 0, vbl = 0, hsLow = 0, vsLow = 0, blankHi = 0;
        bit pe;
        while (ticks < FRAME) begin
            pix_en = ($urandom_range(0, 3) != 0);
            pe = pix_en;
            randPlot(3);
            step();
            checks++;
            if ((act() & expMask) !== (expV & expMask)) begin
                failures++;
                $display("FAIL frame p=%0d got=%h exp=%h", p, act(), expV);
            end
            vbl += int'(vblank_start);
            if (pe) begin
                ticks++;
                hsLow += int'(!vga_hs);
                vsLow += int'(!vga_vs);
                blankHi += int'(vga_blank_n);
            end
        end
        wr_plot = 1'b0;
        checks++;
        if (vbl !== 1) begin
            failures++;
            $display("FAIL vblank_count got=%0d exp=1", vbl);
        end
        checks++;
        if (hsLow !== H_SYNC * V_TOT) begin
            failures++;
            $display("FAIL hs_low got=%0d exp=%0d", hsLow, H_SYNC * V_TOT);
        end
        checks++;
        if (vsLow !== V_SYNC * H_TOT) begin
            failures++;
            $display("FAIL vs_low got=%0d exp=%0d", vsLow, V_SYNC * H_TOT);
        end
        checks++;
        if (blankHi !== H_VIS * V_VIS) begin
            failures++;
            $display("FAIL blank_hi got=%0d exp=%0d", blankHi, H_VIS * V_VIS);
        end
    endtask

    task automatic test_plot();
        int q = (2 * SCALE) * H_TOT + 3 * SCALE;
        logic [27:0] o;
        wr_plot = 1'b1;
        wr_x = 8'd3;
        wr_y = 8'd2;
        wr_colour = 24'hF0A05F;
        pix_en = 1'b1;
        step();
        wr_plot = 1'b0;
        for (int i = 0; i < 2 * FRAME && p != q; i++) begin
            step();
            checks++;
            if ((act() & expMask) !== (expV & expMask)) begin
                failures++;
                $display("FAIL plot_scan p=%0d got=%h exp=%h", p, act(), expV);
            end
        end
        step();
        step();
        o = act();
        checks++;
        if (o[27:4] !== 24'hFFAA55) begin
            failures++;
            $display("FAIL plot_pixel got=%h exp=ffaa55", o[27:4]);
        end
    endtask

    task automatic test_oob();
        pix_en = 1'b0;
        wr_plot = 1'b1;
        wr_colour = 24'hFFFFFF;
        wr_x = 8'(H_RES);
        wr_y = 8'd5;
        step();
        wr_x = 8'd10;
        wr_y = 8'(V_RES);
        step();
        wr_plot = 1'b0;
        for (int i = 0; i < FRAME + 4; i++) begin
            pix_en = ($urandom_range(0, 1) == 1) || i[0];
            step();
            checks++;
            if ((act() & expMask) !== (expV & expMask)) begin
                failures++;
                $display("FAIL oob p=%0d got=%h exp=%h", p, act(), expV);
            end
        end
    endtask

    task automatic test_collision();
        int q = (7 * SCALE) * H_TOT + 5 * SCALE;
        logic [27:0] o;
        pix_en = 1'b1;
        wr_plot = 1'b1;
        wr_x = 8'd5;
        wr_y = 8'd7;
        wr_colour = 24'h000000;
        step();
        wr_plot = 1'b0;
        for (int i = 0; i < 2 * FRAME && p != q; i++) begin
            step();
            checks++;
            if ((act() & expMask) !== (expV & expMask)) begin
                failures++;
                $display("FAIL coll_scan p=%0d got=%h exp=%h", p, act(), expV);
            end
        end
        wr_plot = 1'b1;
        wr_colour = 24'hFFFFFF;
        step();
        wr_plot = 1'b0;
        step();
        o = act();
        checks++;
        if (o[27:1] !== {24'h000000, 3'b111}) begin
            failures++;
            $display("FAIL coll_old got=%h exp=0000007", o[27:1]);
        end
        for (int i = 0; i < 2 * FRAME && p != q; i++) begin
            step();
            checks++;
            if ((act() & expMask) !== (expV & expMask)) begin
                failures++;
                $display("FAIL coll_next p=%0d got=%h exp=%h", p, act(), expV);
            end
        end
        step();
        step();
        o = act();
        checks++;
        if (o[27:4] !== 24'hFFFFFF) begin
            failures++;
            $display("FAIL coll_new got=%h exp=ffffff", o[27:4]);
        end
    endtask

    task automatic test_reset_mid();
        int q = 10 * H_TOT + 15;
        pix_en = 1'b1;
        for (int i = 0; i < 2 * FRAME && p != q; i++) begin
            step();
        end
        reset = 1'b1;
        step();
        checks++;
        if (act() !== RESET_V) begin
            failures++;
            $display("FAIL reset_mid got=%h exp=%h", act(), RESET_V);
        end
        reset = 1'b0;
        for (int i = 0; i < FRAME + 4; i++) begin
            step();
            checks++;
            if ((act() & expMask) !== (expV & expMask)) begin
                failures++;
                $display("FAIL reset_rescan p=%0d got=%h exp=%h", p, act(), expV);
            end
        end
    endtask

    task automatic test_pix_en_low();
        int q = 6 * H_TOT + 9;
        logic [27:0] hold;
        pix_en = 1'b1;
        for (int i = 0; i < 2 * FRAME && p != q; i++) begin
            step();
        end
        hold = act();
        pix_en = 1'b0;
        for (int i = 0; i < 100; i++) begin
            randPlot(0);
            step();
            checks++;
            if (act() !== hold) begin
                failures++;
                $display("FAIL freeze i=%0d got=%h exp=%h", i, act(), hold);
            end
        end
        wr_plot = 1'b0;
        pix_en = 1'b1;
        for (int i = 0; i < FRAME + 4; i++) begin
            step();
            checks++;
            if ((act() & expMask) !== (expV & expMask)) begin
                failures++;
                $display("FAIL thaw p=%0d got=%h exp=%h", p, act(), expV);
            end
        end
    endtask

    initial begin
        for (int a = 0; a < DEPTH; a++) begin
            fb[a] = '0;
            known[a] = 0;
        end
        test_reset();
        test_fill();
        test_frame();
        test_plot();
        test_oob();
        test_collision();
        test_reset_mid();
        test_pix_en_low();
        test_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pixel_scanout.md
Name: pixel_scanout

Overview:
- Receiving end of the pixel-plot interface that the screen drawer drives each clock (x, y, 24-bit colour, plot strobe).
- Stores every plotted pixel in an internal 12-bit-per-pixel framebuffer. Storage truncates each channel to its top 4 bits, the inverse of the drawer's 4-to-8-bit x17 expansion.
- Continuously scans the framebuffer out as 640x480 VGA timing, with each stored pixel replicated SCALE x SCALE.
- Emits a one-cycle vblank_start pulse so the drawer can start its next frame during blanking.

Parameters:
- H_RES, 160, framebuffer width in pixels.
- V_RES, 120, framebuffer height in pixels.
- SCALE, 4, horizontal and vertical replication factor (H_RES*SCALE must equal H_VIS).
- H_VIS, 640, H_FP, 16, H_SYNC, 96, H_BP, 48: horizontal timing in pixel ticks.
- V_VIS, 480, V_FP, 10, V_SYNC, 2, V_BP, 33: vertical timing in lines.

Ports:
- clk  in  1  system clock (50 MHz).
- reset  in  1  synchronous, active-high.
- pix_en  in  1  pixel-tick enable (every other clk for 25 MHz); all scan logic advances only when high.
- wr_x  in  8  plot x coordinate.
- wr_y  in  8  plot y coordinate.
- wr_colour  in  24  plot colour {R[23:16],G[15:8],B[7:0]}.
- wr_plot  in  1  plot strobe; one write per clk when high.
- vga_r, vga_g, vga_b  out  8 each  scanned-out colour.
- vga_hs  out  1  horizontal sync, active-low.
- vga_vs  out  1  vertical sync, active-low.
- vga_blank_n  out  1  high in the visible region.
- vblank_start  out  1  one-clk pulse at the start of vertical blanking.

Behaviour:
- Clock/reset: single clock domain clk; reset is synchronous, active-high.
- Reset values: h_cnt=0, v_cnt=0, pipeline cleared, vga_r/g/b=0, vga_hs=1, vga_vs=1, vga_blank_n=0, vblank_start=0. RAM contents are not cleared.
- Write path, runs every clk independent of pix_en:
  - If wr_plot=1 and wr_x<H_RES and wr_y<V_RES, write {wr_colour[23:20],wr_colour[15:12],wr_colour[7:4]} to address wr_x + wr_y*H_RES (15-bit).
  - Out-of-range writes are silently dropped.
  - No backpressure; the RAM is dual-port, write side only.
- Read/write collision: a same-clk read of the address being written returns the old data (read-before-write). The new value is visible from the next clk.
- Counters, advance only on pix_en:
  - h_cnt runs 0..799; when it wraps to 0, v_cnt increments over 0..524.
  - Both wrap together at (799,524) to (0,0).
- Scan pipeline, 2 pix_en stages:
  - Stage 0: read address = (h_cnt/SCALE) + (v_cnt/SCALE)*H_RES, registered RAM read.
  - Stage 1: RAM output expanded per channel as nibble*17. hs/vs/blank are delayed by the same 2 stages so they stay aligned with the colour.
  - Outputs change only on clk edges where pix_en=1.
- Sync timing, at the counter values before the delay: hs low for h_cnt in [656,751]; vs low for v_cnt in [490,491]; blank_n = (h_cnt<640 && v_cnt<480).
- Blanking: when blank_n=0 at output, vga_r/g/b are forced to 0.
- vblank_start: asserted for exactly one clk on the pix_en edge where h_cnt=799 and v_cnt=479 (entry to line 480). It is not delayed by the pipeline.
- Reset mid-frame: the next clk returns the block to reset values and scanning restarts at (0,0) with no partial-line artefacts. Framebuffer data persists.
- pix_en held low: counters, outputs and vblank_start are frozen; writes still proceed.

Test Plan:
- Reset, then run 800*525 pix_en ticks -> exactly one vblank_start pulse; vga_hs low for 96 ticks per line; vga_vs low for 2 lines (1600 ticks); blank_n high for 640x480 ticks per frame.
- Plot (x=3,y=2,colour=24'hF0A05F), then scan that frame -> output pixels h=12..15 on lines v=8..11 read FF/AA/55, arriving 2 pix_en ticks after the matching counters; all other visible pixels show prior contents.
- Plot x=160,y=5 and x=10,y=120 with colour FFFFFF -> no RAM change; pixels (159,5) and (10,119) are unchanged on the next frame.
- Write address A in the same clk the scan reads A (old 000, new FFF) -> that tick outputs 000; the next frame outputs FF/FF/FF.
- Assert reset at h_cnt=300,v_cnt=200 -> the next clk shows vga_hs=1, vga_vs=1, blank_n=0, rgb=0, counters at 0; previously written pixels reappear in the next frame.
- Hold pix_en low for 100 clks mid-line while plotting -> hs/vs/rgb are constant and no vblank_start fires; the plotted pixels appear in the following frame.
